// File: rtl/draw_arbiter.sv
// ---------------------------------------------------------------------------
// draw_arbiter
//
// Round-robin arbiter that shares one VGA pixel-write port between four
// drawing engines (ball, bottom paddle, top paddle, score). A requester holds
// req high until it is granted; while granted, its coordinates, colour and
// write enable are steered straight through to the VGA port. The grant ends
// when the requester strobes done on its last pixel or drops req (abort).
// Every grant is followed by a one-cycle GAP so that grants are always at
// least two cycles apart.
//
// Optional feature (compile-time macro DRAW_ARBITER_TIMEOUT_EN):
//   A per-grant cycle counter forces release of a grant that has lasted
//   TIMEOUT_CYCLES cycles without done/abort, and pulses timeout_flag.
//   With the macro undefined no counter exists and timeout_flag is tied 0.
//
// Parameters
//   TIMEOUT_CYCLES  max GRANT-state cycles per grant (2..255), used only when
//                   the timeout feature is compiled in.
//
// Ports
//   clk           system clock, all state changes on its rising edge
//   resetn        synchronous active-low reset
//   req[3:0]      per-requester request level (0 ball, 1 bottom paddle,
//                 2 top paddle, 3 score)
//   done[3:0]     per-requester last-pixel strobe (granted requester only)
//   we[3:0]       per-requester pixel write enable
//   x_in[31:0]    four packed 8-bit x coordinates, requester k at [8k+7:8k]
//   y_in[27:0]    four packed 7-bit y coordinates, requester k at [7k+6:7k]
//   color_in[11:0] four packed 3-bit colours, requester k at [3k+2:3k]
//   gnt[3:0]      registered one-hot grant, all-zero when nothing granted
//   x_out[7:0]    VGA x of the granted requester, 0 otherwise
//   y_out[6:0]    VGA y of the granted requester, 0 otherwise
//   color_out[2:0] VGA colour of the granted requester, 0 otherwise
//   writeEn       VGA plot strobe
//   busy          high while in GRANT or GAP
//   timeout_flag  one-cycle pulse on the cycle a grant is forcibly released
// ---------------------------------------------------------------------------
module draw_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  req,
    input  logic [3:0]  done,
    input  logic [3:0]  we,
    input  logic [31:0] x_in,
    input  logic [27:0] y_in,
    input  logic [11:0] color_in,
    output logic [3:0]  gnt,
    output logic [7:0]  x_out,
    output logic [6:0]  y_out,
    output logic [2:0]  color_out,
    output logic        writeEn,
    output logic        busy,
    output logic        timeout_flag
);

    // Elaboration-time guard: the counter is 8 bits wide and a limit below 2
    // would release a grant before its first pixel could be drawn.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("draw_arbiter: TIMEOUT_CYCLES must be in 2..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] ptr;        // round-robin search start
    logic [1:0] g_idx;      // index of the current / last granted requester

    // -----------------------------------------------------------------------
    // Unpack the per-requester buses so the output mux is a plain array index.
    // -----------------------------------------------------------------------
    logic [7:0] x_arr     [4];
    logic [6:0] y_arr     [4];
    logic [2:0] color_arr [4];

    for (genvar k = 0; k < 4; k++) begin : g_unpack
        assign x_arr[k]     = x_in[8*k +: 8];
        assign y_arr[k]     = y_in[7*k +: 7];
        assign color_arr[k] = color_in[3*k +: 3];
    end

    // First set bit of r at or above p, wrapping 3 -> 0. Only meaningful when
    // r is non-zero; the caller checks that.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = p;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = p + 2'(k);    // 2-bit add wraps naturally
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    logic [1:0] next_pick;
    assign next_pick = rr_pick(req, ptr);

    // -----------------------------------------------------------------------
    // Grant-cycle decode
    // -----------------------------------------------------------------------
    logic in_grant;
    logic req_g;
    logic done_g;
    logic we_g;
    logic timeout_hit;      // counter at its limit this GRANT cycle
    logic release_grant;    // grant ends at the coming edge

    assign in_grant = (state == ST_GRANT);
    assign req_g    = req[g_idx];
    assign done_g   = done[g_idx];
    assign we_g     = we[g_idx];

`ifdef DRAW_ARBITER_TIMEOUT_EN
    logic [7:0] grant_cnt;

    assign timeout_hit = in_grant && (grant_cnt == 8'(TIMEOUT_CYCLES - 1));

    // The counter is held at zero outside GRANT, which is the same as
    // clearing it on entry because GRANT is only ever entered from IDLE.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            grant_cnt <= '0;
        end else if (in_grant) begin
            grant_cnt <= grant_cnt + 8'd1;
        end else begin
            grant_cnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign release_grant = in_grant && (done_g || !req_g || timeout_hit);

    // A forced release only counts as a timeout when neither done nor an
    // abort would have ended the grant on the same cycle.
    assign timeout_flag = timeout_hit && req_g && !done_g;

    // -----------------------------------------------------------------------
    // Pixel port steering. done keeps the last pixel; abort and timeout
    // suppress the pixel on the releasing cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, otherwise synthesis would infer a latch.
        x_out     = '0;
        y_out     = '0;
        color_out = '0;
        writeEn   = 1'b0;
        if (in_grant) begin
            x_out     = x_arr[g_idx];
            y_out     = y_arr[g_idx];
            color_out = color_arr[g_idx];
            writeEn   = we_g && (done_g || (req_g && !timeout_hit));
        end
    end

    assign busy = (state != ST_IDLE);

    // -----------------------------------------------------------------------
    // Arbitration FSM. gnt is registered and is non-zero exactly in GRANT.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!resetn) begin
            state <= ST_IDLE;
            ptr   <= 2'd0;
            g_idx <= 2'd0;
            gnt   <= 4'b0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        g_idx <= next_pick;
                        gnt   <= 4'b0001 << next_pick;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (release_grant) begin
                        gnt   <= 4'b0000;
                        ptr   <= g_idx + 2'd1;
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    gnt   <= 4'b0000;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/draw_arbiter.md
DRAW_ARBITER -- requirements
Module: draw_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 64, max GRANT-state cycles per grant when the timeout feature is compiled in (legal range 2..255).
REQ-002 SHALL have port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port: resetn  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port: req  input  4  per-requester draw request, bit0 ball, bit1 bottom paddle, bit2 top paddle, bit3 score; level, held until granted.
REQ-005 SHALL have port: done  input  4  per-requester last-pixel strobe, meaningful only while that requester is granted.
REQ-006 SHALL have port: we  input  4  per-requester pixel write enable.
REQ-007 SHALL have port: x_in  input  32  four packed 8-bit x coordinates, requester k at [8k+7:8k].
REQ-008 SHALL have port: y_in  input  28  four packed 7-bit y coordinates, requester k at [7k+6:7k].
REQ-009 SHALL have port: color_in  input  12  four packed 3-bit colours, requester k at [3k+2:3k].
REQ-010 SHALL have port: gnt  output  4  one-hot registered grant; all-zero when no grant.
REQ-011 SHALL have port: x_out  output  8  VGA x of granted requester.
REQ-012 SHALL have port: y_out  output  7  VGA y of granted requester.
REQ-013 SHALL have port: color_out  output  3  VGA colour of granted requester.
REQ-014 SHALL have port: writeEn  output  1  VGA plot strobe.
REQ-015 SHALL have port: busy  output  1  high in GRANT or GAP.
REQ-016 SHALL have port: timeout_flag  output  1  one-cycle pulse on forced release.

Function
REQ-017 SHALL implement states IDLE, GRANT, GAP; encoding is free.
REQ-018 IDLE: if req != 0, SHALL select the first set bit searching upward from round-robin pointer ptr (2 bits, wrapping 3->0), register gnt one-hot and enter GRANT next cycle; req == 0 stays IDLE.
REQ-019 Grant latency SHALL be exactly one cycle from req sampled high in IDLE to gnt high.
REQ-020 GRANT with granted index g: x_out, y_out, color_out SHALL combinationally equal slice g of x_in, y_in, color_in; writeEn SHALL equal we[g].
REQ-021 GRANT: done[g] high SHALL end the grant; the pixel on that same cycle is still plotted; next cycle gnt = 0, state GAP, ptr = g+1 mod 4.
REQ-022 GRANT: req[g] low without done[g] SHALL abort identically to REQ-021 (pixel on that cycle suppressed, writeEn = 0).
REQ-023 done/we bits of non-granted requesters SHALL be ignored.
REQ-024 GAP SHALL last exactly one cycle with gnt = 0, writeEn = 0, then IDLE; consecutive grants are therefore at least 2 cycles apart (IDLE arbitration cycle + GAP).
REQ-025 Outside GRANT, x_out, y_out, color_out, writeEn SHALL be 0.
REQ-026 Requests arriving during GRANT/GAP SHALL wait; no request is ever dropped while held.
REQ-027 With all four requesting continuously, grant order SHALL be 0,1,2,3,0,... (no starvation).
REQ-028 busy SHALL be 1 exactly in GRANT and GAP.

Reset
REQ-029 resetn low at a clk edge SHALL force state IDLE, ptr = 0, gnt = 0, timeout counter = 0, timeout_flag = 0, regardless of state; mid-grant reset abandons the grant with no GAP cycle.
REQ-030 During and after reset, all outputs SHALL be 0 until the first grant.

Configuration
REQ-031 Macro DRAW_ARBITER_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entering GRANT, increment each GRANT cycle, and on reaching TIMEOUT_CYCLES-1 without done/abort force release as in REQ-022 (pixel suppressed), with timeout_flag high for that cycle.
REQ-032 Macro undefined: no counter is built, grants last until done or abort, timeout_flag SHALL be tied 0.

Verification
REQ-033 Reset then req = 4'b0001, done[0] on 16th GRANT cycle -> gnt = 0001 one cycle after req, 16 writeEn pulses with ball coords, gnt = 0 next, busy 0 two cycles after done.
REQ-034 req = 4'b1111 held, each done after 4 cycles -> grant order 0001,0010,0100,1000,0001; 2 idle cycles between grants.
REQ-035 Granted 2, req[2] dropped on cycle 3 with we[2] = 1 -> writeEn 0 that cycle, GAP, next grant goes to requester 3 if requesting.
REQ-036 Granted 1 with done[1] pulsed and req[3] newly high same cycle -> gnt 1000 three cycles later.
REQ-037 DRAW_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES = 8, done never asserted -> release after 8 GRANT cycles, timeout_flag one-cycle pulse, ptr advances; without macro grant persists 100+ cycles.
REQ-038 resetn low during GRANT of requester 3 -> next cycle gnt = 0, all outputs 0; after release, req = 1111 grants requester 0 first.
